writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- MEM/WB pipeline register plus writeback logic for the 16-bit RISC pipeline.
- Accepts a retiring instruction's ALU result, destination fields and control bits from the memory stage.
- For loads, waits on a variable-latency data-memory return.
- Drives the register-file write port of the decode stage: RegWrite_from_wb, write_reg, write_data.

Parameters:
- MEM_TIMEOUT, 15: cycles spent in WAIT_MEM without mem_data_valid before the load is abandoned; legal range 1..255.
- CNT_W, 16: width of retired_count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage presents an instruction this cycle.
- in_ready  out  1  stage can accept; transfer occurs when in_valid && in_ready at a rising edge.
- alu_result  in  16  ALU output of the instruction.
- rt  in  3  instruction[9:7].
- rd  in  3  instruction[6:4].
- Sig_RegDst  in  1  1 selects rd as destination, 0 selects rt.
- Sig_MemToReg  in  1  1 means write-back data comes from memory (load).
- Sig_RegWrite  in  1  instruction writes the register file.
- mem_read_data  in  16  data-memory read return.
- mem_data_valid  in  1  mem_read_data is valid this cycle; sampled only in WAIT_MEM.
- RegWrite_from_wb  out  1  one-cycle register-file write strobe.
- write_reg  out  3  destination register.
- write_data  out  16  write-back data.
- mem_timeout  out  1  sticky flag, set when a load is abandoned.
- retired_count  out  CNT_W  instructions retired.

Behaviour:
- Reset (async, rst=1): state IDLE, RegWrite_from_wb=0, write_reg=0, write_data=0, mem_timeout=0, retired_count=0, timeout counter=0. A pending load in WAIT_MEM is discarded with no write.
- All outputs are registered except in_ready. in_ready = (state != WAIT_MEM).
- Destination register: dest = Sig_RegDst ? rd : rt, captured at transfer.
- States:
  - IDLE/RUN: accepting.
  - WAIT_MEM: load outstanding.
- Non-load transfer (Sig_MemToReg=0) at edge T, during cycle T+1:
  - write_data=alu_result, write_reg=dest, RegWrite_from_wb=Sig_RegWrite.
  - retired_count increments.
  - State stays IDLE, so back-to-back transfers every cycle are legal and each produces its own one-cycle strobe.
- Load transfer (Sig_MemToReg=1) at edge T:
  - Enter WAIT_MEM; latch dest and Sig_RegWrite; clear timeout counter; RegWrite_from_wb=0 during T+1.
- In WAIT_MEM, at each edge:
  - If mem_data_valid=1: on the next cycle write_data=mem_read_data, write_reg=latched dest, RegWrite_from_wb=latched RegWrite; retired_count increments; return to IDLE.
  - Else the timeout counter increments. When it reaches MEM_TIMEOUT, set mem_timeout, return to IDLE, issue no write strobe, and do not increment retired_count.
- Minimum load latency: data valid in the first WAIT_MEM cycle gives its strobe 2 cycles after transfer.
- When mem_data_valid and the timeout are reached on the same edge, data wins and no timeout is raised.
- Strobe shape: RegWrite_from_wb is never high for more than one cycle per instruction. When no write occurs, write_reg and write_data hold their last values.
- mem_data_valid outside WAIT_MEM is ignored.
- retired_count wraps from 2^CNT_W-1 to 0.
- mem_timeout clears only on reset.
- Instructions with Sig_RegWrite=0 (stores, branches) still retire and count, but never strobe.

Optional Feature:
- R0_WRITE_GUARD_EN:
  - Defined: any write with dest=3'b000 is suppressed (RegWrite_from_wb stays 0); the instruction still retires and counts.
  - Undefined: writes to register 0 strobe like any other register.

Test Plan:
- Reset while in WAIT_MEM with a load outstanding -> all outputs 0, in_ready=1. A later mem_data_valid pulse produces no strobe.
- Non-load: alu_result=16'h1234, rd=5, Sig_RegDst=1, Sig_RegWrite=1 at edge T -> during T+1, RegWrite_from_wb=1, write_reg=5, write_data=16'h1234, retired_count=1. Strobe 0 at T+2.
- Three back-to-back non-load transfers with data 16'h0001/16'h0002/16'h0003 and rt=1/2/3, Sig_RegDst=0 -> three consecutive one-cycle strobes in order; retired_count=3.
- Load with dest rt=4, mem_data_valid asserted 3 cycles after transfer with 16'hBEEF -> in_ready=0 for those cycles. Strobe with write_reg=4, write_data=16'hBEEF on the cycle after valid, then in_ready=1.
- Load with mem_data_valid never asserted, MEM_TIMEOUT=15 -> after 15 WAIT_MEM cycles, mem_timeout=1, state IDLE, no strobe, retired_count unchanged.
- Write to register 0 (alu_result=16'hFFFF, rd=0, Sig_RegDst=1, Sig_RegWrite=1) -> strobe with R0_WRITE_GUARD_EN undefined; no strobe with it defined. retired_count increments in both builds.

Source files
------------

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//   MEM/WB pipeline register and register-file writeback for the 16-bit RISC
//   pipeline. Non-load instructions retire one cycle after transfer. Loads park
//   in WAIT_MEM until the data memory returns (mem_data_valid) or until
//   MEM_TIMEOUT cycles elapse, in which case the load is abandoned and the
//   sticky mem_timeout flag is raised.
//
// Optional build macro:
//   R0_WRITE_GUARD_EN - when defined, writes whose destination is register 0
//                       never raise RegWrite_from_wb. The instruction still
//                       retires and counts.
//
// Parameters:
//   MEM_TIMEOUT (1..255) - WAIT_MEM cycles without data before abandoning a load
//   CNT_W                - width of retired_count
//
// Ports:
//   clk, rst           - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  - transfer handshake from the memory stage
//   alu_result, rt, rd - instruction result and register fields
//   Sig_RegDst         - 1 selects rd as destination, 0 selects rt
//   Sig_MemToReg       - instruction is a load
//   Sig_RegWrite       - instruction writes the register file
//   mem_read_data      - data-memory read return
//   mem_data_valid     - read return valid (only looked at in WAIT_MEM)
//   RegWrite_from_wb   - one-cycle register-file write strobe
//   write_reg          - destination register
//   write_data         - write-back data
//   mem_timeout        - sticky abandoned-load flag
//   retired_count      - retired instruction count (wraps)
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      alu_result,
  input  logic [2:0]       rt,
  input  logic [2:0]       rd,
  input  logic             Sig_RegDst,
  input  logic             Sig_MemToReg,
  input  logic             Sig_RegWrite,
  input  logic [15:0]      mem_read_data,
  input  logic             mem_data_valid,
  output logic             RegWrite_from_wb,
  output logic [2:0]       write_reg,
  output logic [15:0]      write_data,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_t;

`ifdef R0_WRITE_GUARD_EN
  localparam logic R0_GUARD = 1'b1;
`else
  localparam logic R0_GUARD = 1'b0;
`endif

  // Last counter value before the timeout fires; the edge that would take the
  // counter to MEM_TIMEOUT is the one that abandons the load.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_r, state_s;
  logic [2:0]       dest_lat_r, dest_lat_s;
  logic             we_lat_r, we_lat_s;
  logic [7:0]       tcnt_r, tcnt_s;
  logic             wr_en_r, wr_en_s;
  logic [2:0]       write_reg_r, write_reg_s;
  logic [15:0]      write_data_r, write_data_s;
  logic             timeout_r, timeout_s;
  logic [CNT_W-1:0] count_r, count_s;
  logic [2:0]       dest_s;

  // A write to r0 is blocked only in guarded builds.
  function automatic logic write_allowed(input logic [2:0] dest);
    return !(R0_GUARD && (dest == 3'b000));
  endfunction

  assign dest_s           = Sig_RegDst ? rd : rt;
  assign in_ready         = (state_r != ST_WAIT_MEM);
  assign RegWrite_from_wb = wr_en_r;
  assign write_reg        = write_reg_r;
  assign write_data       = write_data_r;
  assign mem_timeout      = timeout_r;
  assign retired_count    = count_r;

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      dest_lat_r   <= 3'd0;
      we_lat_r     <= 1'b0;
      tcnt_r       <= 8'd0;
      wr_en_r      <= 1'b0;
      write_reg_r  <= 3'd0;
      write_data_r <= 16'd0;
      timeout_r    <= 1'b0;
      count_r      <= '0;
    end else begin
      state_r      <= state_s;
      dest_lat_r   <= dest_lat_s;
      we_lat_r     <= we_lat_s;
      tcnt_r       <= tcnt_s;
      wr_en_r      <= wr_en_s;
      write_reg_r  <= write_reg_s;
      write_data_r <= write_data_s;
      timeout_r    <= timeout_s;
      count_r      <= count_s;
    end
  end

  // Next-state and next-output logic; the strobe defaults low so it can only
  // ever last one cycle per retiring instruction.
  always_comb begin
    state_s      = state_r;
    dest_lat_s   = dest_lat_r;
    we_lat_s     = we_lat_r;
    tcnt_s       = tcnt_r;
    wr_en_s      = 1'b0;
    write_reg_s  = write_reg_r;
    write_data_s = write_data_r;
    timeout_s    = timeout_r;
    count_s      = count_r;

    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (Sig_MemToReg) begin
            state_s    = ST_WAIT_MEM;
            dest_lat_s = dest_s;
            we_lat_s   = Sig_RegWrite;
            tcnt_s     = 8'd0;
          end else begin
            write_data_s = alu_result;
            write_reg_s  = dest_s;
            wr_en_s      = Sig_RegWrite && write_allowed(dest_s);
            count_s      = count_r + CNT_W'(1);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT_MEM: begin
        // Data arriving on the timeout edge still wins.
        if (mem_data_valid) begin
          state_s      = ST_IDLE;
          write_data_s = mem_read_data;
          write_reg_s  = dest_lat_r;
          wr_en_s      = we_lat_r && write_allowed(dest_lat_r);
          count_s      = count_r + CNT_W'(1);
        end else if (tcnt_r == TMO_LAST) begin
          state_s   = ST_IDLE;
          timeout_s = 1'b1;
          tcnt_s    = tcnt_r + 8'd1;
        end else begin
          tcnt_s = tcnt_r + 8'd1;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//   Transaction-level bench for writeback_stage. Each issued instruction's
//   outcome (strobe cycle, data, timeout) is decided when it is issued, from
//   the chosen memory latency, and written into the expected-output variables
//   for each following cycle. A negedge process compares every output against
//   those expectations every cycle; directed tests add literal checks.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  localparam int TMO   = 15;
  localparam int CNT_W = 5;   // small so the counter wraps during the run

`ifdef R0_WRITE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      alu_result;
  logic [2:0]       rt;
  logic [2:0]       rd;
  logic             Sig_RegDst;
  logic             Sig_MemToReg;
  logic             Sig_RegWrite;
  logic [15:0]      mem_read_data;
  logic             mem_data_valid;
  logic             RegWrite_from_wb;
  logic [2:0]       write_reg;
  logic [15:0]      write_data;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired_count;

  writeback_stage #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .alu_result       (alu_result),
    .rt               (rt),
    .rd               (rd),
    .Sig_RegDst       (Sig_RegDst),
    .Sig_MemToReg     (Sig_MemToReg),
    .Sig_RegWrite     (Sig_RegWrite),
    .mem_read_data    (mem_read_data),
    .mem_data_valid   (mem_data_valid),
    .RegWrite_from_wb (RegWrite_from_wb),
    .write_reg        (write_reg),
    .write_data       (write_data),
    .mem_timeout      (mem_timeout),
    .retired_count    (retired_count)
  );

  // Expected outputs for the current cycle.
  logic        e_ready;
  logic        e_we;
  logic [2:0]  e_reg;
  logic [15:0] e_data;
  logic        e_to;
  int          e_cnt;
  bit          chk_en;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [CNT_W-1:0] cnt_exp;
      cnt_exp = CNT_W'(e_cnt);
      chk("in_ready", 32'(in_ready), 32'(e_ready));
      chk("RegWrite_from_wb", 32'(RegWrite_from_wb), 32'(e_we));
      chk("write_reg", 32'(write_reg), 32'(e_reg));
      chk("write_data", 32'(write_data), 32'(e_data));
      chk("mem_timeout", 32'(mem_timeout), 32'(e_to));
      chk("retired_count", 32'(retired_count), 32'(cnt_exp));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    e_ready = 1'b1; e_we = 1'b0; e_reg = 3'd0; e_data = 16'd0; e_to = 1'b0; e_cnt = 0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    #1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // A cycle with no transfer; random noise on the ignored memory return.
  task automatic idle;
    in_valid       = 1'b0;
    alu_result     = 16'($urandom);
    mem_data_valid = 1'($urandom);
    mem_read_data  = 16'($urandom);
    tick();
    e_we = 1'b0;
    e_ready = 1'b1;
  endtask

  task automatic drive_instr(input logic [15:0] d, input logic [2:0] f_rt, input logic [2:0] f_rd,
                             input logic dst, input logic load, input logic rw);
    in_valid = 1'b1; alu_result = d; rt = f_rt; rd = f_rd;
    Sig_RegDst = dst; Sig_MemToReg = load; Sig_RegWrite = rw;
    mem_data_valid = 1'($urandom);
    mem_read_data  = 16'($urandom);
  endtask

  task automatic issue_alu(input logic [15:0] d, input logic [2:0] f_rt, input logic [2:0] f_rd,
                           input logic dst, input logic rw);
    logic [2:0] dest;
    dest = dst ? f_rd : f_rt;
    drive_instr(d, f_rt, f_rd, dst, 1'b0, rw);
    tick();
    e_ready = 1'b1;
    e_we    = rw && !(GUARD && dest == 3'd0);
    e_reg   = dest;
    e_data  = d;
    e_cnt++;
  endtask

  // Load whose memory return arrives in the lat-th waiting cycle; lat > TMO
  // means the return never comes within the window.
  task automatic issue_load(input logic [2:0] f_rt, input logic [2:0] f_rd, input logic dst,
                            input logic rw, input int lat, input logic [15:0] md);
    logic [2:0] dest;
    dest = dst ? f_rd : f_rt;
    drive_instr(16'($urandom), f_rt, f_rd, dst, 1'b1, rw);
    tick();
    e_ready = 1'b0;
    e_we    = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      in_valid       = 1'($urandom);
      alu_result     = 16'($urandom);
      Sig_MemToReg   = 1'($urandom);
      mem_data_valid = (k == lat);
      mem_read_data  = (k == lat) ? md : 16'($urandom);
      tick();
      if (k == lat) begin
        e_ready = 1'b1;
        e_we    = rw && !(GUARD && dest == 3'd0);
        e_reg   = dest;
        e_data  = md;
        e_cnt++;
        break;
      end else if (k == TMO) begin
        e_ready = 1'b1;
        e_we    = 1'b0;
        e_to    = 1'b1;
      end else begin
        e_we = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1; in_valid = 1'b0; alu_result = 16'd0; rt = 3'd0; rd = 3'd0;
    Sig_RegDst = 1'b0; Sig_MemToReg = 1'b0; Sig_RegWrite = 1'b0;
    mem_read_data = 16'd0; mem_data_valid = 1'b0;
    model_reset();
    #2;
    chk_en = 1'b1;
    do_reset();
    chk("lit_reset_ready", 32'(in_ready), 32'd1);
    chk("lit_reset_cnt", 32'(retired_count), 32'd0);

    // Single non-load write.
    issue_alu(16'h1234, 3'd2, 3'd5, 1'b1, 1'b1);
    chk("lit_alu_we", 32'(RegWrite_from_wb), 32'd1);
    chk("lit_alu_reg", 32'(write_reg), 32'd5);
    chk("lit_alu_data", 32'(write_data), 32'h1234);
    chk("lit_alu_cnt", 32'(retired_count), 32'd1);
    idle();
    chk("lit_alu_strobe_drop", 32'(RegWrite_from_wb), 32'd0);

    // Reset while a load is outstanding.
    drive_instr(16'h0, 3'd6, 3'd1, 1'b0, 1'b1, 1'b1);
    tick(); e_ready = 1'b0; e_we = 1'b0;
    in_valid = 1'b0; mem_data_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("lit_rst_wait_ready", 32'(in_ready), 32'd1);
    chk("lit_rst_wait_reg", 32'(write_reg), 32'd0);
    chk("lit_rst_wait_data", 32'(write_data), 32'd0);
    chk("lit_rst_wait_cnt", 32'(retired_count), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    mem_data_valid = 1'b1; mem_read_data = 16'hDEAD;
    tick(); e_we = 1'b0;
    chk("lit_rst_no_strobe", 32'(RegWrite_from_wb), 32'd0);
    mem_data_valid = 1'b0;

    // Three back-to-back non-loads.
    issue_alu(16'h0001, 3'd1, 3'd7, 1'b0, 1'b1);
    chk("lit_b2b_reg1", 32'(write_reg), 32'd1);
    issue_alu(16'h0002, 3'd2, 3'd7, 1'b0, 1'b1);
    chk("lit_b2b_we2", 32'(RegWrite_from_wb), 32'd1);
    chk("lit_b2b_data2", 32'(write_data), 32'h0002);
    issue_alu(16'h0003, 3'd3, 3'd7, 1'b0, 1'b1);
    chk("lit_b2b_reg3", 32'(write_reg), 32'd3);
    chk("lit_b2b_cnt", 32'(retired_count), 32'd3);
    idle();

    // Load, data three cycles later.
    issue_load(3'd4, 3'd0, 1'b0, 1'b1, 3, 16'hBEEF);
    chk("lit_load_we", 32'(RegWrite_from_wb), 32'd1);
    chk("lit_load_reg", 32'(write_reg), 32'd4);
    chk("lit_load_data", 32'(write_data), 32'hBEEF);
    chk("lit_load_ready", 32'(in_ready), 32'd1);
    idle();

    // Load never answered.
    issue_load(3'd2, 3'd3, 1'b1, 1'b1, TMO + 5, 16'h0);
    chk("lit_to_flag", 32'(mem_timeout), 32'd1);
    chk("lit_to_we", 32'(RegWrite_from_wb), 32'd0);
    chk("lit_to_cnt", 32'(retired_count), 32'd4);
    chk("lit_to_reg_hold", 32'(write_reg), 32'd4);
    idle();

    // Write to r0.
    issue_alu(16'hFFFF, 3'd4, 3'd0, 1'b1, 1'b1);
    chk("lit_r0_we", 32'(RegWrite_from_wb), GUARD ? 32'd0 : 32'd1);
    chk("lit_r0_cnt", 32'(retired_count), 32'd5);
    idle();

    // Data on the timeout edge wins.
    issue_load(3'd6, 3'd0, 1'b0, 1'b1, TMO, 16'h5A5A);
    chk("lit_tie_data", 32'(write_data), 32'h5A5A);
    chk("lit_tie_cnt", 32'(retired_count), 32'd6);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        idle();
      end else if (sel < 7) begin
        issue_alu(16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        issue_load(3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(1, TMO + 3)), 16'($urandom));
      end
      if (n == 150) begin
        do_reset();
      end
    end
    idle();
    idle();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
